// File: rtl/core_lsu_outstanding.sv
// MEM-stage load/store unit driving a req/gnt/rvalid data port.
// Loads in flight are tracked in a tag FIFO so that back-to-back loads do not wait for rvalid.
`timescale 1ns/1ps
module core_lsu_outstanding #(
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 2,
    parameter int REG_ADDR_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_valid_i,
    input  logic                      m_load_i,
    input  logic                      m_store_i,
    input  logic [1:0]                m_size_i,
    input  logic                      m_unsigned_i,
    input  logic [31:0]               m_addr_i,
    input  logic [31:0]               m_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] m_rd_addr_i,
    output logic                      m_ready_o,
    output logic                      data_req_o,
    output logic                      data_wr_o,
    output logic [ADDR_WIDTH-1:0]     data_addr_o,
    output logic [3:0]                data_be_o,
    output logic [31:0]               data_wdata_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    input  logic [31:0]               data_rdata_i,
    output logic                      w_wr_o,
    output logic [REG_ADDR_WIDTH-1:0] w_addr_o,
    output logic [31:0]               w_data_o,
    output logic                      misaligned_o,
    output logic                      resp_err_o,
    output logic                      pending_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [1:0]                size;
        logic                      uns;
        logic [1:0]                off;
    } tag_t;

    tag_t             fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic        acc;
    logic        mis;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  off;
    tag_t        head;
    logic [31:0] shifted;
    logic [31:0] load_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign off        = m_addr_i[1:0];
    assign acc        = m_valid_i & (m_load_i | m_store_i);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mis = 1'b0;
        unique case (m_size_i)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            default: mis = |off;
        endcase
    end

    // Loads stall while the tag FIFO is full; a same-cycle pop does not free a slot.
    assign data_req_o  = acc & ~mis & (m_store_i | ~fifo_full);
    assign accept      = data_req_o & data_gnt_i;
    assign push        = accept & m_load_i;
    assign pop         = data_rvalid_i & ~fifo_empty;
    assign m_ready_o   = ~acc | mis | accept;
    assign data_wr_o   = acc & m_store_i;
    assign data_addr_o = {m_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign pending_o   = ~fifo_empty;

    always_comb begin
        data_be_o    = 4'b1111;
        data_wdata_o = m_wdata_i;
        unique case (m_size_i)
            2'd0: begin
                data_be_o    = 4'b0001 << off;
                data_wdata_o = {4{m_wdata_i[7:0]}};
            end
            2'd1: begin
                data_be_o    = 4'b0011 << off;
                data_wdata_o = {2{m_wdata_i[15:0]}};
            end
            default: begin
                data_be_o    = 4'b1111;
                data_wdata_o = m_wdata_i;
            end
        endcase
    end

    // Response alignment uses the tag recorded when the load was accepted.
    assign head    = fifo_q[rd_ptr_q];
    assign shifted = data_rdata_i >> {head.off, 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (head.size)
            2'd0:    load_data = {{24{~head.uns & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{16{~head.uns & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // NOTE: the tag storage has no reset; entries are only read once count_q marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{rd: m_rd_addr_i, size: m_size_i, uns: m_unsigned_i, off: off};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_wr_o       <= 1'b0;
            w_addr_o     <= '0;
            w_data_o     <= '0;
            misaligned_o <= 1'b0;
            resp_err_o   <= 1'b0;
        end else begin
            w_wr_o       <= pop;
            misaligned_o <= acc & mis;
            resp_err_o   <= resp_err_o | (data_rvalid_i & fifo_empty);
            if (pop) begin
                w_addr_o <= head.rd;
                w_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_core_lsu_outstanding.sv
// Self-checking bench for core_lsu_outstanding: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the load/store unit.
`timescale 1ns/1ps
module tb_core_lsu_outstanding;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_load, m_store, m_unsigned;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        m_ready_o, data_req_o, data_wr_o;
    logic [15:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        w_wr_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic        misaligned_o, resp_err_o, pending_o;

    core_lsu_outstanding #(.ADDR_WIDTH(16), .MAX_OUTSTANDING(MAXO), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid_i(m_valid), .m_load_i(m_load), .m_store_i(m_store), .m_size_i(m_size),
        .m_unsigned_i(m_unsigned), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rd_addr_i(m_rd),
        .m_ready_o(m_ready_o), .data_req_o(data_req_o), .data_wr_o(data_wr_o),
        .data_addr_o(data_addr_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .w_wr_o(w_wr_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .misaligned_o(misaligned_o), .resp_err_o(resp_err_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: outstanding loads as a queue of what each one needs to be returned.
    typedef struct {
        logic [4:0] rd;
        int         nbytes;
        logic       uns;
        int         off;
    } tag_t;

    tag_t        q[$];
    logic        mdl_err;
    logic [31:0] mdl_wdata;
    logic        last_acc, last_ready;

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_result(input logic [31:0] rd_word, input tag_t t);
        logic [31:0] v;
        logic [31:0] mask;
        v = rd_word >> (8 * t.off);
        if (t.nbytes == 4) return v;
        mask = (32'd1 << (8 * t.nbytes)) - 32'd1;
        v = v & mask;
        if (!t.uns && v[8 * t.nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_in(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic g, input logic rv, input logic [31:0] rdt);
        m_valid = v; m_load = ld; m_store = st; m_size = sz; m_unsigned = un;
        m_addr = a; m_wdata = wd; m_rd = rd; gnt = g; rvalid = rv; rdata = rdt;
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdt);
        set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, rv, rdt);
    endtask

    // Called in the low clock phase with inputs already driven; returns at the next negedge.
    task automatic step();
        logic        acc, mis, exp_req, exp_ready, exp_wwr, exp_mis;
        logic [4:0]  exp_waddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          nb, off;
        tag_t        t;
        #1;
        nb  = size_bytes(m_size);
        off = int'(m_addr[1:0]);
        acc = m_valid && (m_load || m_store);
        mis = (off % nb) != 0;
        exp_req   = acc && !mis && (m_store || q.size() < MAXO);
        exp_ready = !acc || mis || (exp_req && gnt);
        check("req", 32'(data_req_o), 32'(exp_req));
        check("ready", 32'(m_ready_o), 32'(exp_ready));
        check("pending", 32'(pending_o), 32'(q.size() != 0));
        if (acc && !mis) begin
            for (int i = 0; i < 4; i++) begin
                exp_be[i] = (i >= off) && (i < off + nb);
                exp_wd[8*i +: 8] = m_wdata[8*(i % nb) +: 8];
            end
            check("wr", 32'(data_wr_o), 32'(m_store));
            check("addr", 32'(data_addr_o), m_addr & 32'h0000_FFFC);
            if (m_store) begin
                check("be", 32'(data_be_o), 32'(exp_be));
                check("wdata", data_wdata_o, exp_wd);
            end
        end
        last_acc   = acc;
        last_ready = exp_ready;

        exp_mis   = acc && mis;
        exp_wwr   = 1'b0;
        exp_waddr = 5'd0;
        if (rvalid) begin
            if (q.size() > 0) begin
                t = q.pop_front();
                exp_wwr   = 1'b1;
                exp_waddr = t.rd;
                mdl_wdata = load_result(rdata, t);
            end else begin
                mdl_err = 1'b1;
            end
        end
        if (exp_req && gnt && m_load)
            q.push_back('{rd: m_rd, nbytes: nb, uns: m_unsigned, off: off});

        @(posedge clk);
        #1;
        check("w_wr", 32'(w_wr_o), 32'(exp_wwr));
        if (exp_wwr) check("w_addr", 32'(w_addr_o), 32'(exp_waddr));
        check("w_data", w_data_o, mdl_wdata);
        check("misaligned", 32'(misaligned_o), 32'(exp_mis));
        check("resp_err", 32'(resp_err_o), 32'(mdl_err));
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_w_wr", 32'(w_wr_o), 32'h0);
        check("rst_w_addr", 32'(w_addr_o), 32'h0);
        check("rst_w_data", w_data_o, 32'h0);
        check("rst_mis", 32'(misaligned_o), 32'h0);
        check("rst_err", 32'(resp_err_o), 32'h0);
        check("rst_pending", 32'(pending_o), 32'h0);
        q.delete();
        mdl_err   = 1'b0;
        mdl_wdata = 32'h0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic held;
        rst_n = 1'b0;
        idle(1'b0, 32'h0);
        @(negedge clk);
        do_reset();

        // LW with rvalid on the next cycle
        set_in(1, 1, 0, 2'd2, 0, 32'h104, 32'h0, 5'd5, 1, 0, 32'h0); step();
        idle(1'b1, 32'hDEADBEEF); step();
        check("t1_wwr", 32'(w_wr_o), 32'h1);
        check("t1_waddr", 32'(w_addr_o), 32'h5);
        check("t1_wdata", w_data_o, 32'hDEADBEEF);
        idle(1'b0, 32'h0); step();

        // Sub-word loads with sign/zero extension
        set_in(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd6, 1, 0, 32'h0); step();
        idle(1'b1, 32'h80123456); step();
        check("t2_lb", w_data_o, 32'hFFFFFF80);
        set_in(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd7, 1, 0, 32'h0); step();
        idle(1'b1, 32'h80123456); step();
        check("t2_lbu", w_data_o, 32'h00000080);
        set_in(1, 1, 0, 2'd1, 0, 32'h102, 32'h0, 5'd8, 1, 0, 32'h0); step();
        idle(1'b1, 32'h80011234); step();
        check("t2_lh", w_data_o, 32'hFFFF8001);

        // Sub-word stores
        set_in(1, 0, 1, 2'd0, 0, 32'h101, 32'h000000A5, 5'd0, 1, 0, 32'h0);
        #1;
        check("t3_sb_be", 32'(data_be_o), 32'b0010);
        check("t3_sb_wdata", data_wdata_o, 32'hA5A5A5A5);
        check("t3_sb_wr", 32'(data_wr_o), 32'h1);
        step();
        set_in(1, 0, 1, 2'd1, 0, 32'h102, 32'h0000BEEF, 5'd0, 1, 0, 32'h0);
        #1;
        check("t3_sh_be", 32'(data_be_o), 32'b1100);
        step();

        // Outstanding limit: third load stalls until the first rvalid has popped
        set_in(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd1, 1, 0, 32'h0); step();
        set_in(1, 1, 0, 2'd2, 0, 32'h304, 32'h0, 5'd2, 1, 0, 32'h0); step();
        set_in(1, 1, 0, 2'd2, 0, 32'h308, 32'h0, 5'd3, 1, 0, 32'h0);
        #1;
        check("t4_req", 32'(data_req_o), 32'h0);
        check("t4_ready", 32'(m_ready_o), 32'h0);
        step();
        rvalid = 1'b1; rdata = 32'h11111111;
        #1;
        check("t4_nobypass", 32'(data_req_o), 32'h0);
        step();
        check("t4_wb1", 32'(w_addr_o), 32'h1);
        rvalid = 1'b0; step();
        idle(1'b1, 32'h22222222); step();
        check("t4_wb2", 32'(w_addr_o), 32'h2);
        idle(1'b1, 32'h33333333); step();
        check("t4_wb3", 32'(w_addr_o), 32'h3);
        check("t4_wb3_data", w_data_o, 32'h33333333);

        // Misaligned word load
        set_in(1, 1, 0, 2'd2, 0, 32'h102, 32'h0, 5'd9, 1, 0, 32'h0);
        #1;
        check("t5_req", 32'(data_req_o), 32'h0);
        check("t5_ready", 32'(m_ready_o), 32'h1);
        step();
        check("t5_pulse", 32'(misaligned_o), 32'h1);
        idle(1'b0, 32'h0); step();
        check("t5_pulse_end", 32'(misaligned_o), 32'h0);

        // Reset mid-transaction drops the tag; the late rvalid becomes an error
        set_in(1, 1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd4, 1, 0, 32'h0); step();
        do_reset();
        idle(1'b1, 32'h12345678); step();
        check("rst_late_err", 32'(resp_err_o), 32'h1);
        do_reset();

        // Randomized traffic
        held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!held) begin
                m_valid    = ($urandom % 4) != 0;
                m_load     = $urandom % 2;
                m_store    = !m_load && (($urandom % 4) != 0);
                m_size     = 2'($urandom);
                m_unsigned = $urandom % 2;
                m_addr     = $urandom;
                if (($urandom % 4) != 0) m_addr[1:0] = (m_size == 2'd0) ? m_addr[1:0] :
                                                      (m_size == 2'd1) ? {m_addr[1], 1'b0} : 2'b00;
                m_wdata    = $urandom;
                m_rd       = 5'($urandom);
            end
            gnt    = ($urandom % 4) != 0;
            rvalid = (q.size() > 0) && (($urandom % 2) != 0);
            rdata  = $urandom;
            step();
            held = last_acc && !last_ready;
        end

        // Store held under gnt=0, then an unmatched rvalid
        do_reset();
        set_in(1, 0, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 5'd0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_stall", 32'(m_ready_o), 32'h0);
            check("t6_stable_addr", 32'(data_addr_o), 32'h200);
            step();
        end
        gnt = 1'b1; step();
        idle(1'b1, 32'h0); step();
        check("t6_err", 32'(resp_err_o), 32'h1);
        idle(1'b0, 32'h0); step(); step();
        check("t6_err_sticky", 32'(resp_err_o), 32'h1);
        do_reset();
        idle(1'b0, 32'h0); step();
        check("t6_err_cleared", 32'(resp_err_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
